// File: rtl/mem_dump_master_if.sv
// rtl/mem_dump_master_if.sv - data-memory bus and dump-stream bundle for mem_dump_master
//
// Groups the data-memory port and the dump output stream.
//   mem_address    : word address to data memory
//   mem_write_data : write data to data memory
//   mem_write      : write enable to data memory
//   mem_read_data  : combinational read data (same cycle as mem_address)
//   out_valid      : dump word available
//   out_data       : dump word
//   out_index      : offset of out_data from the start address
//   out_ready      : sink accepts the word
// master = the engine side, slave = memory/sink side.
interface mem_dump_master_if #(
   parameter int CNT_W = 9
);
   logic [31:0]      mem_address;
   logic [31:0]      mem_write_data;
   logic             mem_write;
   logic [31:0]      mem_read_data;
   logic             out_valid;
   logic [31:0]      out_data;
   logic [CNT_W-1:0] out_index;
   logic             out_ready;

   modport master (
      output mem_address, mem_write_data, mem_write,
      output out_valid, out_data, out_index,
      input  mem_read_data, out_ready
   );

   modport slave (
      input  mem_address, mem_write_data, mem_write,
      input  out_valid, out_data, out_index,
      output mem_read_data, out_ready
   );
endinterface

// File: rtl/mem_dump_master.sv
// rtl/mem_dump_master.sv - data-memory dump/fill bus-master engine
//
// Reads a contiguous range of data-memory words and streams them out with a
// valid/ready handshake, or fills a range with a constant word.
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle request, honoured only when idle
//   mode        : 0 = dump, 1 = fill (latched on start)
//   base_addr   : first word address (latched on start)
//   count       : number of words (latched on start)
//   fill_data   : word written in fill mode (latched on start)
//   busy        : high whenever not idle
//   done        : one-cycle completion pulse
//   err         : range error, valid with done, held until next start
//   bus         : memory port and dump stream (master modport)
module mem_dump_master #(
   parameter int MEM_DEPTH = 257,
   parameter int CNT_W     = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [31:0]      base_addr,
   input  logic [CNT_W-1:0] count,
   input  logic [31:0]      fill_data,
   output logic             busy,
   output logic             done,
   output logic             err,
   mem_dump_master_if.master bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CHECK   = 3'd1,
      READ    = 3'd2,
      PRESENT = 3'd3,
      FILL    = 3'd4,
      FINISH  = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic             mode_q, mode_d;
   logic [31:0]      base_q, base_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      fill_q, fill_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic             err_q, err_d;
   logic [31:0]      out_data_q, out_data_d;
   logic [CNT_W-1:0] out_index_q, out_index_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic             mem_we_q, mem_we_d;

   // 33-bit end address so a base near 2^32 cannot wrap past the check
   logic [32:0]      end_addr;
   logic             last_word;

   assign end_addr  = {1'b0, base_q} + 33'(count_q);
   assign last_word = (idx_q == count_q - CNT_W'(1));

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      base_d      = base_q;
      count_d     = count_q;
      fill_d      = fill_q;
      idx_d       = idx_q;
      err_d       = err_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      mem_addr_d  = 32'd0;
      mem_wdata_d = 32'd0;
      mem_we_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d  = mode;
               base_d  = base_addr;
               count_d = count;
               fill_d  = fill_data;
               idx_d   = '0;
               err_d   = 1'b0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (count_q == '0) begin
               state_d = FINISH;
            end else if (end_addr > 33'(MEM_DEPTH)) begin
               err_d   = 1'b1;
               state_d = FINISH;
            end else begin
               state_d = mode_q ? FILL : READ;
            end
         end
         READ: begin
            out_data_d  = bus.mem_read_data;
            out_index_d = idx_q;
            state_d     = PRESENT;
         end
         PRESENT: begin
            if (bus.out_ready) begin
               if (last_word) begin
                  state_d = FINISH;
               end else begin
                  idx_d   = idx_q + CNT_W'(1);
                  state_d = READ;
               end
            end
         end
         FILL: begin
            if (last_word) begin
               state_d = FINISH;
            end else begin
               idx_d = idx_q + CNT_W'(1);
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Memory outputs are registered from the next state, so they are
      // valid for the whole cycle the engine spends in READ or FILL.
      if (state_d == READ || state_d == FILL) begin
         mem_addr_d = base_q + 32'(idx_d);
      end
      if (state_d == FILL) begin
         mem_wdata_d = fill_q;
         mem_we_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         base_q      <= 32'd0;
         count_q     <= '0;
         fill_q      <= 32'd0;
         idx_q       <= '0;
         err_q       <= 1'b0;
         out_data_q  <= 32'd0;
         out_index_q <= '0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         mem_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         base_q      <= base_d;
         count_q     <= count_d;
         fill_q      <= fill_d;
         idx_q       <= idx_d;
         err_q       <= err_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
      end
   end

   assign bus.mem_address    = mem_addr_q;
   assign bus.mem_write_data = mem_wdata_q;
   assign bus.mem_write      = mem_we_q;
   assign bus.out_valid      = (state_q == PRESENT);
   assign bus.out_data       = out_data_q;
   assign bus.out_index      = out_index_q;
   assign busy               = (state_q != IDLE);
   assign done               = (state_q == FINISH);
   assign err                = err_q;

endmodule

// File: tb/tb_mem_dump_master.sv
// tb/tb_mem_dump_master.sv - directed self-checking bench for mem_dump_master
module tb_mem_dump_master;
   localparam int MEM_DEPTH = 257;
   localparam int CNT_W     = 9;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             mode = 1'b0;
   logic [31:0]      base_addr = 32'd0;
   logic [CNT_W-1:0] count = '0;
   logic [31:0]      fill_data = 32'd0;
   logic             busy, done, err;

   mem_dump_master_if #(.CNT_W(CNT_W)) bus ();

   mem_dump_master #(.MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .base_addr (base_addr),
      .count     (count),
      .fill_data (fill_data),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .bus       (bus.master)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:MEM_DEPTH-1];
   int n_chk = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int vld_cnt = 0;
   int done_cnt = 0;

   always_comb begin
      if (bus.mem_address < 32'(MEM_DEPTH)) bus.mem_read_data = mem[bus.mem_address[8:0]];
      else bus.mem_read_data = 32'd0;
   end

   // Memory and event monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.mem_write) begin
         wr_cnt++;
         if (bus.mem_address < 32'(MEM_DEPTH)) mem[bus.mem_address[8:0]] = bus.mem_write_data;
      end
      if (bus.out_valid) vld_cnt++;
      if (done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_cnt();
      wr_cnt = 0;
      vld_cnt = 0;
      done_cnt = 0;
   endtask

   // Returns at the negedge after the start edge (engine in CHECK)
   task automatic do_start(input logic m, input logic [31:0] b, input logic [CNT_W-1:0] n,
                           input logic [31:0] f);
      @(negedge clk);
      start = 1'b1; mode = m; base_addr = b; count = n; fill_data = f;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_addr"}, bus.mem_address, 32'd0);
      chk({tag, "_wdata"}, bus.mem_write_data, 32'd0);
      chk({tag, "_we"}, 32'(bus.mem_write), 32'd0);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   task automatic run_dump(input logic [31:0] b, input int n, input bit rnd, input string tag);
      logic [31:0] exp [4];
      int k = 0;
      bit first = 1'b1;
      bit got_done = 1'b0;
      for (int i = 0; i < 4; i++) exp[i] = (i < n) ? mem[b[8:0] + 9'(i)] : 32'd0;
      clr_cnt();
      bus.out_ready = 1'b0;
      do_start(1'b0, b, CNT_W'(n), 32'd0);
      @(negedge clk);
      chk({tag, "_valid_read"}, 32'(bus.out_valid), 32'd0);
      for (int c = 0; c < 300 && !got_done; c++) begin
         @(negedge clk);
         if (done) begin
            got_done = 1'b1;
            bus.out_ready = 1'b0;
         end else if (bus.out_valid && k < 4) begin
            chk({tag, "_data"}, bus.out_data, exp[k]);
            chk({tag, "_index"}, 32'(bus.out_index), 32'(k));
            if (rnd && first) begin
               bus.out_ready = 1'b0;
               first = 1'b0;
            end else begin
               bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
               if (bus.out_ready) begin
                  k++;
                  first = 1'b1;
               end
            end
         end else begin
            bus.out_ready = 1'b0;
         end
      end
      chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
      chk({tag, "_words"}, 32'(k), 32'(n));
      chk({tag, "_err"}, 32'(err), 32'd0);
      @(negedge clk);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      chk({tag, "_no_write"}, 32'(wr_cnt), 32'd0);
      chk({tag, "_one_done"}, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      bus.out_ready = 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 32'h5000_0000 + 32'(i);

      // Reset values
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      chk("rst_data", bus.out_data, 32'd0);
      chk("rst_index", 32'(bus.out_index), 32'd0);
      rst = 1'b0;

      // Fill base=10 count=4
      clr_cnt();
      do_start(1'b1, 32'd10, CNT_W'(4), 32'hDEAD_BEEF);
      chk("fill_check_busy", 32'(busy), 32'd1);
      chk("fill_check_we", 32'(bus.mem_write), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("fill_we", 32'(bus.mem_write), 32'd1);
         chk("fill_addr", bus.mem_address, 32'd10 + 32'(i));
         chk("fill_wdata", bus.mem_write_data, 32'hDEAD_BEEF);
         chk("fill_done_early", 32'(done), 32'd0);
      end
      @(negedge clk);
      chk("fill_done", 32'(done), 32'd1);
      chk("fill_err", 32'(err), 32'd0);
      chk("fill_we_off", 32'(bus.mem_write), 32'd0);
      chk("fill_addr_off", bus.mem_address, 32'd0);
      @(negedge clk);
      chk("fill_idle", 32'(busy), 32'd0);
      chk("fill_done_off", 32'(done), 32'd0);
      chk("fill_wr_cnt", 32'(wr_cnt), 32'd4);
      chk("fill_mem9", mem[9], 32'h5000_0009);
      for (int i = 10; i < 14; i++) chk("fill_mem", mem[i], 32'hDEAD_BEEF);
      chk("fill_mem14", mem[14], 32'h5000_000E);

      // Reset mid-fill after 5 writes
      clr_cnt();
      do_start(1'b1, 32'd0, CNT_W'(20), 32'hA5A5_0001);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("midrst_wr_cnt", 32'(wr_cnt), 32'd5);
      chk("midrst_mem4", mem[4], 32'hA5A5_0001);
      chk("midrst_mem5", mem[5], 32'h5000_0005);
      chk("midrst_idle", 32'(busy), 32'd0);

      // Dump with random stalls
      mem[239] = 32'h111; mem[240] = 32'h222; mem[241] = 32'h333;
      run_dump(32'd239, 3, 1'b1, "dump");

      // Boundary: last address 256 accepted
      mem[254] = 32'hAAA0_0254; mem[255] = 32'hAAA0_0255; mem[256] = 32'hAAA0_0256;
      run_dump(32'd254, 3, 1'b0, "bnd_ok");

      // Boundary: base=255 count=3 out of range
      clr_cnt();
      do_start(1'b1, 32'd255, CNT_W'(3), 32'hFFFF_FFFF);
      @(negedge clk);
      chk("bnd_err_done", 32'(done), 32'd1);
      chk("bnd_err_err", 32'(err), 32'd1);
      @(negedge clk);
      chk("bnd_err_idle", 32'(busy), 32'd0);
      chk("bnd_err_held", 32'(err), 32'd1);
      chk("bnd_err_no_write", 32'(wr_cnt), 32'd0);
      chk("bnd_err_no_valid", 32'(vld_cnt), 32'd0);
      chk("bnd_err_mem255", mem[255], 32'hAAA0_0255);

      // Huge base must not wrap into range
      clr_cnt();
      do_start(1'b0, 32'hFFFF_FFFF, CNT_W'(2), 32'd0);
      @(negedge clk);
      chk("wrap_done", 32'(done), 32'd1);
      chk("wrap_err", 32'(err), 32'd1);
      chk("wrap_no_valid", 32'(vld_cnt), 32'd0);

      // count=0 with a second start while busy
      @(negedge clk);
      clr_cnt();
      do_start(1'b0, 32'd5, CNT_W'(0), 32'd0);
      start = 1'b1; mode = 1'b1; base_addr = 32'd0; count = CNT_W'(5); fill_data = 32'h1234_5678;
      @(negedge clk);
      start = 1'b0;
      chk("cnt0_done", 32'(done), 32'd1);
      chk("cnt0_err", 32'(err), 32'd0);
      repeat (6) @(negedge clk);
      chk("cnt0_one_done", 32'(done_cnt), 32'd1);
      chk("cnt0_no_write", 32'(wr_cnt), 32'd0);
      chk("cnt0_no_valid", 32'(vld_cnt), 32'd0);
      chk("cnt0_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
